// File: rtl/raptor64_divider.sv
// Radix-2 restoring divider: signed/unsigned WID-bit divide with a fixed
// WID+1 cycle latency and a single-cycle divide-by-zero shortcut.
module raptor64_divider #(
   parameter int WID = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld,
   input  logic           sgn,
   input  logic [WID-1:0] a,
   input  logic [WID-1:0] b,
   output logic [WID-1:0] qo,
   output logic [WID-1:0] ro,
   output logic           done,
   output logic           busy,
   output logic           dvByZr
);

   localparam int CW = $clog2(WID + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [WID-1:0] r_rem;
   logic [WID-1:0] r_quo;
   logic [WID-1:0] r_dvs;
   logic [WID-1:0] r_a;
   logic           r_sgn;
   logic           r_bneg;
   logic           r_dbz;

   logic [WID-1:0] w_amag;
   logic [WID-1:0] w_bmag;
   logic [WID:0]   w_shift;
   logic [WID-1:0] w_sub;
   logic           w_borrow;
   logic           w_qneg;
   logic           w_rneg;
   logic [WID-1:0] w_qfix;
   logic [WID-1:0] w_rfix;

   // Magnitudes as WID-bit unsigned values; the most negative input maps to 2^(WID-1).
   assign w_amag   = (sgn && a[WID-1]) ? (~a + WID'(1)) : a;
   assign w_bmag   = (sgn && b[WID-1]) ? (~b + WID'(1)) : b;
   assign w_shift  = {r_rem, r_quo[WID-1]};
   assign w_borrow = (w_shift < {1'b0, r_dvs});
   assign w_sub    = w_shift[WID-1:0] - r_dvs;
   assign w_qneg   = r_sgn & (r_a[WID-1] ^ r_bneg);
   assign w_rneg   = r_sgn & r_a[WID-1];
   assign w_qfix   = w_qneg ? (~r_quo + WID'(1)) : r_quo;
   assign w_rfix   = w_rneg ? (~r_rem + WID'(1)) : r_rem;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a zero divisor jumps straight to the completion state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (ld) begin
               w_state_nxt = (b == {WID{1'b0}}) ? FIX : DIV;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         DIV: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = FIX;
            end else begin
               w_state_nxt = DIV;
            end
         end
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= {CW{1'b0}};
         r_rem  <= {WID{1'b0}};
         r_quo  <= {WID{1'b0}};
         r_dvs  <= {WID{1'b0}};
         r_a    <= {WID{1'b0}};
         r_sgn  <= 1'b0;
         r_bneg <= 1'b0;
         r_dbz  <= 1'b0;
         qo     <= {WID{1'b0}};
         ro     <= {WID{1'b0}};
         done   <= 1'b0;
         busy   <= 1'b0;
         dvByZr <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ld) begin
                  r_sgn  <= sgn;
                  r_a    <= a;
                  r_bneg <= b[WID-1];
                  r_dvs  <= w_bmag;
                  r_rem  <= {WID{1'b0}};
                  r_quo  <= w_amag;
                  r_cnt  <= CW'(WID);
                  r_dbz  <= (b == {WID{1'b0}});
                  done   <= 1'b0;
                  dvByZr <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            DIV: begin
               r_rem <= w_borrow ? w_shift[WID-1:0] : w_sub;
               r_quo <= {r_quo[WID-2:0], ~w_borrow};
               r_cnt <= r_cnt - CW'(1);
            end
            FIX: begin
               if (r_dbz) begin
                  qo     <= {WID{1'b1}};
                  ro     <= r_a;
                  dvByZr <= 1'b1;
               end else begin
                  qo <= w_qfix;
                  ro <= w_rfix;
               end
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
